// File: rtl/touch_sampler.sv
// ADS7846/XPT2046 poll sampler: converts X then Y while the pen is down and
// presents the pair on a valid/ready port. Define TOUCH_AVG_EN for 4-sample averaging.
module touch_sampler #(
  parameter int CLK_DIV     = 25,
  parameter int POLL_CYCLES = 500000
) (
  input  logic        FAB_CLK,
  input  logic        M2F_RESET_N,
  input  logic        TS_PENIRQ_N,
  input  logic        TS_MISO,
  output logic        TS_SCLK,
  output logic        TS_CS_N,
  output logic        TS_MOSI,
  output logic [11:0] XY_X,
  output logic [11:0] XY_Y,
  output logic        XY_VALID,
  input  logic        XY_READY,
  output logic        PEN_DOWN,
  output logic        OVERRUN,
  output logic [2:0]  state_dbg
);

  // Handshake: a pair moves when XY_VALID && XY_READY at a rising edge; while
  // VALID=1 and READY=0 the pair and VALID hold, and a new result is dropped (OVERRUN).

`ifdef TOUCH_AVG_EN
  localparam int NS = 4;
`else
  localparam int NS = 1;
`endif
  localparam logic [31:0] DIV_LAST  = 32'(CLK_DIV - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
  localparam logic [1:0]  SMP_LAST  = 2'(NS - 1);

  typedef enum logic [2:0] {
    WAIT, CHECK, CS_SETUP, SHIFT, CS_HOLD, NEXT, PRESENT
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [4:0]  bit_idx;
  logic [11:0] shreg;
  logic        axis;
  logic [1:0]  smp;
  logic [1:0]  pen_sync;
  logic        penirq_sync;
  logic [7:0]  cmd;
  logic [11:0] res_x;
  logic [11:0] res_y;

`ifdef TOUCH_AVG_EN
  logic [13:0] acc_x;
  logic [13:0] acc_y;
  always_comb begin
    res_x = 12'(acc_x >> 2);
    res_y = 12'(acc_y >> 2);
  end
`else
  logic [11:0] smp_x;
  logic [11:0] smp_y;
  always_comb begin
    res_x = smp_x;
    res_y = smp_y;
  end
`endif

  assign penirq_sync = pen_sync[1];
  assign cmd         = axis ? 8'h90 : 8'hD0;
  assign state_dbg   = state;

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      pen_sync <= 2'b11;
      state    <= WAIT;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      axis     <= 1'b0;
      smp      <= '0;
`ifdef TOUCH_AVG_EN
      acc_x    <= '0;
      acc_y    <= '0;
`else
      smp_x    <= '0;
      smp_y    <= '0;
`endif
      TS_SCLK  <= 1'b0;
      TS_CS_N  <= 1'b1;
      TS_MOSI  <= 1'b0;
      XY_X     <= '0;
      XY_Y     <= '0;
      XY_VALID <= 1'b0;
      PEN_DOWN <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      pen_sync <= {pen_sync[0], TS_PENIRQ_N};
      OVERRUN  <= 1'b0;
      if (XY_VALID && XY_READY) XY_VALID <= 1'b0;
      case (state)
        WAIT: begin
          if (cnt == POLL_LAST) begin
            cnt   <= '0;
            state <= CHECK;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        CHECK: begin
          PEN_DOWN <= !penirq_sync;
          cnt      <= '0;
          if (penirq_sync) begin
            state <= WAIT;
          end else begin
`ifdef TOUCH_AVG_EN
            acc_x <= '0;
            acc_y <= '0;
`endif
            axis    <= 1'b0;
            smp     <= '0;
            TS_CS_N <= 1'b0;
            state   <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            TS_MOSI <= cmd[7];
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!TS_SCLK) begin
              TS_SCLK <= 1'b1;
              // Rising edges 10..21 carry the 12 data bits, MSB first.
              if (bit_idx >= 5'd9 && bit_idx <= 5'd20) shreg <= {shreg[10:0], TS_MISO};
            end else begin
              TS_SCLK <= 1'b0;
              if (bit_idx == 5'd23) begin
                TS_MOSI <= 1'b0;
                state   <= CS_HOLD;
              end else begin
                bit_idx <= bit_idx + 5'd1;
                TS_MOSI <= (bit_idx < 5'd7) ? cmd[3'(5'd6 - bit_idx)] : 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        CS_HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            TS_CS_N <= 1'b1;
            state   <= NEXT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        NEXT: begin
          if (cnt == 32'd0) begin
`ifdef TOUCH_AVG_EN
            if (axis) acc_y <= acc_y + {2'b00, shreg};
            else      acc_x <= acc_x + {2'b00, shreg};
`else
            if (axis) smp_y <= shreg;
            else      smp_x <= shreg;
`endif
          end
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (smp == SMP_LAST) begin
              smp <= '0;
              if (axis) begin
                state <= PRESENT;
              end else begin
                axis    <= 1'b1;
                TS_CS_N <= 1'b0;
                state   <= CS_SETUP;
              end
            end else begin
              smp     <= smp + 2'd1;
              TS_CS_N <= 1'b0;
              state   <= CS_SETUP;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        PRESENT: begin
          if (penirq_sync) begin
            PEN_DOWN <= 1'b0;
          end else if (!XY_VALID || XY_READY) begin
            XY_X     <= res_x;
            XY_Y     <= res_y;
            XY_VALID <= 1'b1;
          end else begin
            OVERRUN <= 1'b1;
          end
          cnt   <= '0;
          state <= WAIT;
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_touch_sampler.sv
// Bench for touch_sampler: behavioural ADS7846 model, table vectors, corner
// sequences (reset, pen up/release, backpressure) and randomized polls.
module tb_touch_sampler;

  localparam int CLK_DIV     = 2;
  localparam int POLL_CYCLES = 100;
`ifdef TOUCH_AVG_EN
  localparam int NS = 4;
`else
  localparam int NS = 1;
`endif
  localparam int FRAME_LEN   = 50 * CLK_DIV;
  localparam int POLL_BUDGET = POLL_CYCLES + 2 * NS * (FRAME_LEN + 20) + 200;
  localparam logic [2:0] ST_PRESENT = 3'd6;
  localparam int N_RAND = 16;

  logic        FAB_CLK = 1'b0;
  logic        M2F_RESET_N;
  logic        TS_PENIRQ_N;
  logic        TS_MISO = 1'b0;
  logic        TS_SCLK, TS_CS_N, TS_MOSI;
  logic [11:0] XY_X, XY_Y;
  logic        XY_VALID;
  logic        XY_READY;
  logic        PEN_DOWN, OVERRUN;
  logic [2:0]  state_dbg;

  touch_sampler #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL_CYCLES)) dut (
    .FAB_CLK(FAB_CLK), .M2F_RESET_N(M2F_RESET_N), .TS_PENIRQ_N(TS_PENIRQ_N),
    .TS_MISO(TS_MISO), .TS_SCLK(TS_SCLK), .TS_CS_N(TS_CS_N), .TS_MOSI(TS_MOSI),
    .XY_X(XY_X), .XY_Y(XY_Y), .XY_VALID(XY_VALID), .XY_READY(XY_READY),
    .PEN_DOWN(PEN_DOWN), .OVERRUN(OVERRUN), .state_dbg(state_dbg)
  );

  // ---- clock / reset ----
  always #5 FAB_CLK = ~FAB_CLK;
  int cyc = 0;
  always @(posedge FAB_CLK) cyc++;

  // ---- scoreboard state ----
  int n_cmp = 0;
  int n_fail = 0;
  int ovr_count = 0;
  logic [23:0] exp_q[$];
  logic [11:0] x_q[$];
  logic [11:0] y_q[$];
  logic [7:0]  cmd_q[$];
  int          frame_len_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge FAB_CLK);
    #1;
  endtask

  // Random samples for one poll go into the controller model; returns the expected pair.
  task automatic push_poll(output logic [23:0] pair);
    int sx, sy;
    logic [11:0] xv, yv;
    sx = 0;
    sy = 0;
    for (int s = 0; s < NS; s++) begin
      xv = 12'($urandom_range(0, 4095));
      yv = 12'($urandom_range(0, 4095));
      x_q.push_back(xv);
      y_q.push_back(yv);
      sx += int'(xv);
      sy += int'(yv);
    end
    pair = {12'(sx / NS), 12'(sy / NS)};
  endtask

  // ---- touch controller model: decodes the command, answers with queued samples ----
  int          f_start, f_edges;
  logic [7:0]  f_cmd;
  logic [11:0] f_data;
  always begin
    @(negedge TS_CS_N);
    f_start = cyc;
    f_edges = 0;
    f_cmd   = 8'h00;
    f_data  = 12'h000;
    while (TS_CS_N === 1'b0) begin
      @(posedge TS_SCLK or negedge TS_SCLK or posedge TS_CS_N);
      if (TS_CS_N !== 1'b0) break;
      if (TS_SCLK) begin
        f_edges++;
        if (f_edges <= 8) f_cmd = {f_cmd[6:0], TS_MOSI};
        if (f_edges == 8) begin
          if (f_cmd == 8'hD0 && x_q.size() > 0) f_data = x_q.pop_front();
          else if (f_cmd == 8'h90 && y_q.size() > 0) f_data = y_q.pop_front();
        end
      end else begin
        if (f_edges >= 9 && f_edges <= 20) TS_MISO = f_data[20 - f_edges];
        else TS_MISO = 1'b0;
      end
    end
    TS_MISO = 1'b0;
    if (f_edges == 24) begin
      cmd_q.push_back(f_cmd);
      frame_len_q.push_back(cyc - f_start);
    end
  end

  // ---- transfer monitor ----
  always @(negedge FAB_CLK) begin
    if (M2F_RESET_N) begin
      if (OVERRUN) ovr_count++;
      if (XY_VALID && XY_READY) begin
        if (exp_q.size() == 0) begin
          check("xfer_unexpected", {8'h0, XY_X, XY_Y}, 32'hFFFF_FFFF);
        end else begin
          check("xfer_pair", {8'h0, XY_X, XY_Y}, {8'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---- table vectors ----
  typedef struct packed {
    logic [3:0][11:0] xs;
    logic [3:0][11:0] ys;
    logic [11:0]      ex;
    logic [11:0]      ey;
  } vec_t;
  vec_t vecs[4];

  function automatic vec_t mk(input logic [11:0] x0, x1, x2, x3, y0, y1, y2, y3, ex, ey);
    vec_t v;
    v.xs[0] = x0; v.xs[1] = x1; v.xs[2] = x2; v.xs[3] = x3;
    v.ys[0] = y0; v.ys[1] = y1; v.ys[2] = y2; v.ys[3] = y3;
    v.ex = ex;
    v.ey = ey;
    return v;
  endfunction

  initial begin
    int n, base, ovr_base;
    bit ok;
    logic [23:0] pa, pb, pc, pd;

`ifdef TOUCH_AVG_EN
    vecs[0] = mk(12'd100, 12'd101, 12'd102, 12'd105, 12'h123, 12'h123, 12'h123, 12'h123, 12'd102, 12'h123);
    vecs[1] = mk(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'd0, 12'd0, 12'd0, 12'd3, 12'hFFF, 12'h000);
    vecs[2] = mk(12'd1, 12'd2, 12'd3, 12'd4, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFC, 12'd2, 12'hFFE);
    vecs[3] = mk(12'h800, 12'h7FF, 12'h800, 12'h7FF, 12'hAAA, 12'h555, 12'hAAA, 12'h555, 12'h7FF, 12'h7FF);
`else
    vecs[0] = mk(12'hABC, 12'h0, 12'h0, 12'h0, 12'h123, 12'h0, 12'h0, 12'h0, 12'hABC, 12'h123);
    vecs[1] = mk(12'hFFF, 12'h0, 12'h0, 12'h0, 12'h000, 12'h0, 12'h0, 12'h0, 12'hFFF, 12'h000);
    vecs[2] = mk(12'h000, 12'h0, 12'h0, 12'h0, 12'hFFF, 12'h0, 12'h0, 12'h0, 12'h000, 12'hFFF);
    vecs[3] = mk(12'h800, 12'h0, 12'h0, 12'h0, 12'h555, 12'h0, 12'h0, 12'h0, 12'h800, 12'h555);
`endif

    M2F_RESET_N = 1'b0;
    TS_PENIRQ_N = 1'b1;
    XY_READY    = 1'b0;
    tick(5);
    check("rst_ctl", 32'({TS_SCLK, TS_CS_N, TS_MOSI, XY_VALID, PEN_DOWN, OVERRUN}), 32'b010000);
    check("rst_xy", {8'h0, XY_X, XY_Y}, 32'h0);
    M2F_RESET_N = 1'b1;

    // Reset asserted in the middle of a SHIFT phase
    TS_PENIRQ_N = 1'b0;
    n = 0;
    while (TS_CS_N && n < POLL_BUDGET) begin tick(1); n++; end
    check("rst_frame_start", 32'(TS_CS_N), 32'd0);
    tick(20);
    check("rst_pen_before", 32'(PEN_DOWN), 32'd1);
    #3 M2F_RESET_N = 1'b0;
    #1;
    check("rst_async_ctl", 32'({TS_SCLK, TS_CS_N, TS_MOSI, XY_VALID, PEN_DOWN, OVERRUN}), 32'b010000);
    tick(3);
    check("rst_hold_ctl", 32'({TS_SCLK, TS_CS_N, TS_MOSI}), 32'b010);
    M2F_RESET_N = 1'b1;
    n = 0;
    while (TS_CS_N && n < 3 * POLL_CYCLES) begin tick(1); n++; end
    n_cmp++;
    if (n < POLL_CYCLES || n > POLL_CYCLES + 8) begin
      n_fail++;
      $display("FAIL rst_first_cs: got %0d cycles, required %0d..%0d", n, POLL_CYCLES, POLL_CYCLES + 8);
    end
    TS_PENIRQ_N = 1'b1;
    tick(2 * NS * (FRAME_LEN + 10) + 40);
    check("rst_poll_discard_valid", 32'(XY_VALID), 32'd0);
    check("rst_poll_discard_pen", 32'(PEN_DOWN), 32'd0);

    // Table vectors: one poll each, READY held low until checked
    for (int v = 0; v < 4; v++) begin
      cmd_q.delete();
      frame_len_q.delete();
      for (int s = 0; s < NS; s++) begin
        x_q.push_back(vecs[v].xs[s]);
        y_q.push_back(vecs[v].ys[s]);
      end
      exp_q.push_back({vecs[v].ex, vecs[v].ey});
      TS_PENIRQ_N = 1'b0;
      n = 0;
      while (!XY_VALID && n < POLL_BUDGET) begin tick(1); n++; end
      ok = XY_VALID;
      TS_PENIRQ_N = 1'b1;
      check("vec_valid", 32'(ok), 32'd1);
      check("vec_x", 32'(XY_X), 32'(vecs[v].ex));
      check("vec_y", 32'(XY_Y), 32'(vecs[v].ey));
      check("vec_pen", 32'(PEN_DOWN), 32'd1);
      check("vec_frames", 32'(cmd_q.size()), 32'(2 * NS));
      for (int f = 0; f < cmd_q.size(); f++) begin
        check("vec_cmd", 32'(cmd_q[f]), (f < NS) ? 32'hD0 : 32'h90);
        check("vec_frame_len", 32'(frame_len_q[f]), 32'(FRAME_LEN));
      end
      tick(3);
      check("vec_hold", {7'h0, XY_VALID, XY_X, XY_Y}, {7'h0, 1'b1, vecs[v].ex, vecs[v].ey});
      XY_READY = 1'b1;
      tick(1);
      XY_READY = 1'b0;
      check("vec_valid_drop", 32'(XY_VALID), 32'd0);
    end
    check("vec_drained", 32'(exp_q.size()), 32'd0);

    // Pen up: no frames, no result
    base = cmd_q.size();
    tick(3 * (POLL_CYCLES + 4));
    check("penup_frames", 32'(cmd_q.size()), 32'(base));
    check("penup_pen", 32'(PEN_DOWN), 32'd0);
    check("penup_valid", 32'(XY_VALID), 32'd0);

    // Pen released during the Y frames: result discarded
    ovr_base = ovr_count;
    push_poll(pa);
    base = cmd_q.size();
    TS_PENIRQ_N = 1'b0;
    n = 0;
    while (!(cmd_q.size() >= base + NS && !TS_CS_N) && n < POLL_BUDGET) begin tick(1); n++; end
    check("rel_in_y_frame", 32'(cmd_q.size()), 32'(base + NS));
    check("rel_pen_mid", 32'(PEN_DOWN), 32'd1);
    TS_PENIRQ_N = 1'b1;
    n = 0;
    while (cmd_q.size() < base + 2 * NS && n < POLL_BUDGET) begin tick(1); n++; end
    tick(CLK_DIV + 5);
    check("rel_pen", 32'(PEN_DOWN), 32'd0);
    check("rel_valid", 32'(XY_VALID), 32'd0);
    check("rel_frames", 32'(cmd_q.size()), 32'(base + 2 * NS));
    check("rel_ovr", 32'(ovr_count), 32'(ovr_base));

    // Backpressure: pair A held, pair B dropped, pair C loaded with READY in PRESENT
    push_poll(pa);
    push_poll(pb);
    push_poll(pc);
    exp_q.push_back(pa);
    TS_PENIRQ_N = 1'b0;
    n = 0;
    while (!XY_VALID && n < POLL_BUDGET) begin tick(1); n++; end
    check("bp_first", {7'h0, XY_VALID, XY_X, XY_Y}, {7'h0, 1'b1, pa});
    n = 0;
    while (!OVERRUN && n < POLL_BUDGET) begin tick(1); n++; end
    check("bp_ovr_seen", 32'(OVERRUN), 32'd1);
    tick(1);
    check("bp_ovr_width", 32'(OVERRUN), 32'd0);
    check("bp_hold", {7'h0, XY_VALID, XY_X, XY_Y}, {7'h0, 1'b1, pa});
    n = 0;
    while (state_dbg != ST_PRESENT && n < POLL_BUDGET) begin tick(1); n++; end
    XY_READY = 1'b1;
    exp_q.push_back(pc);
    tick(1);
    XY_READY = 1'b0;
    TS_PENIRQ_N = 1'b1;
    check("bp_reload", {7'h0, XY_VALID, XY_X, XY_Y}, {7'h0, 1'b1, pc});
    tick(2);
    check("bp_ovr_count", 32'(ovr_count - ovr_base), 32'd1);
    XY_READY = 1'b1;
    tick(1);
    XY_READY = 1'b0;
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_valid_drop", 32'(XY_VALID), 32'd0);

    // Randomized polls with random READY
    ovr_base = ovr_count;
    for (int p = 0; p < N_RAND; p++) begin
      push_poll(pd);
      exp_q.push_back(pd);
    end
    TS_PENIRQ_N = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < N_RAND * POLL_BUDGET) begin
      XY_READY = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    XY_READY = 1'b0;
    TS_PENIRQ_N = 1'b1;
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_ovr", 32'(ovr_count), 32'(ovr_base));
    check("rand_samples_used", 32'(x_q.size() + y_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/touch_sampler.md
# touch_sampler

Fabric-side sampler for a resistive touch controller using the ADS7846/XPT2046 serial protocol. It drives the controller's SPI pins, converts X then Y on a fixed poll interval while the pen is down, and optionally averages the samples. Each coordinate pair is handed downstream to the touch_screen MSS fabric interface over a valid/ready handshake. It sits between the touch-panel pins and the MSS.

## Interface
- CLK_DIV, 25: FAB_CLK cycles per SCLK half-period; legal range 2..255.
- POLL_CYCLES, 500000: FAB_CLK cycles from the end of one poll to the start of the next; minimum 16.
- FAB_CLK  in  1  system clock; all logic rising-edge.
- M2F_RESET_N  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to FAB_CLK.
- TS_PENIRQ_N  in  1  pen-down from the controller, active-low, asynchronous; 2-FF synchronized.
- TS_MISO  in  1  controller data out.
- TS_SCLK  out  1  SPI clock, mode 0, idles low.
- TS_CS_N  out  1  controller chip select, active-low.
- TS_MOSI  out  1  command bits, MSB first.
- XY_X  out  12  X coordinate.
- XY_Y  out  12  Y coordinate.
- XY_VALID  out  1  coordinate pair available.
- XY_READY  in  1  consumer accepts the pair.
- PEN_DOWN  out  1  synchronized pen state, sampled at each poll start.
- OVERRUN  out  1  one-cycle pulse when a result is dropped.

## Operation
- Reset values:
  - TS_SCLK=0, TS_CS_N=1, TS_MOSI=0.
  - XY_X=0, XY_Y=0, XY_VALID=0, PEN_DOWN=0, OVERRUN=0.
  - Poll timer is cleared; FSM enters WAIT.
- FSM states: WAIT, CHECK, CS_SETUP, SHIFT, CS_HOLD, NEXT, PRESENT.
- WAIT: the poll timer counts to POLL_CYCLES, then the FSM moves to CHECK.
- CHECK:
  - PEN_DOWN <= !penirq_sync.
  - Pen up: return to WAIT.
  - Pen down: clear the accumulators, set axis=X, sample count=0, go to CS_SETUP.
- CS_SETUP: TS_CS_N=0 for CLK_DIV cycles, then SHIFT.
- SHIFT: 24 SCLK periods.
  - Command is 0xD0 for X and 0x90 for Y (12-bit, differential, PD=00).
  - MOSI updates while SCLK is low, bits 1..8; it is 0 for bits 9..24.
  - MISO is sampled on SCLK rising edges 10..21 (1-based), MSB first, into a 12-bit shift register.
- CS_HOLD: after the 24th falling edge, CS_N stays low for CLK_DIV cycles, then goes high.
- NEXT:
  - Adds the sample to a 14-bit per-axis accumulator.
  - Advances to the next sample or axis. The order is all X samples, then all Y samples.
  - CS_N stays high for CLK_DIV cycles before the next CS_SETUP.
  - After the final Y sample, go to PRESENT.
- PRESENT:
  - If penirq_sync reads pen-up, the result is discarded, PEN_DOWN=0, and the FSM returns to WAIT.
  - Otherwise the result is loaded per the handshake rules below, then WAIT.
- Arithmetic:
  - Averaged result = accumulator[13:2].
  - Single-sample result = the 12-bit sample.
  - No rounding is applied.
- Handshake:
  - A transfer occurs when XY_VALID && XY_READY on a rising edge; XY_VALID drops the next cycle unless reloaded.
  - XY_X, XY_Y and XY_VALID hold stable while VALID=1 and READY=0.
  - Load in PRESENT with VALID=0: the pair is loaded and VALID=1.
  - Load in PRESENT with VALID=1 and READY=0: the new pair is dropped, the old pair is kept, OVERRUN pulses.
  - Load in PRESENT with VALID=1 and READY=1 in the same cycle: the new pair is loaded, VALID stays 1, no OVERRUN.
- Pen release mid-conversion does not abort the SPI frame; it is checked only in PRESENT.
- Reset asserted mid-frame: CS_N and SCLK go to idle immediately and any partial result is lost.

## Timing
- SCLK period = 2*CLK_DIV FAB_CLK cycles, 50% duty.
- One conversion = CS_SETUP + 24 SCLK periods + CS_HOLD = 50*CLK_DIV cycles.
- Inter-frame CS_N high time = CLK_DIV cycles.
- Full poll with N samples per axis: 2N*51*CLK_DIV cycles, plus a few FSM cycles, then POLL_CYCLES of WAIT.
- XY_VALID rises one cycle after PRESENT is entered.
- PEN_DOWN reflects TS_PENIRQ_N with a worst-case delay of 2 FAB_CLK cycles plus one poll interval.

## Configuration
- TOUCH_AVG_EN defined: 4 samples per axis, accumulated and divided by 4.
- TOUCH_AVG_EN undefined:
  - 1 sample per axis; result = raw sample.
  - The accumulator logic is removed.

## Test plan
- Reset: hold M2F_RESET_N low mid-SHIFT.
  - Outputs go to the reset values within the same cycle (asynchronous).
  - After release, the first CS_N fall occurs no earlier than POLL_CYCLES later.
- Single poll: CLK_DIV=2, POLL_CYCLES=100, TOUCH_AVG_EN undefined, pen low, model returns X=0xABC and Y=0x123.
  - MOSI shows 0xD0 then 0x90.
  - XY_X=0xABC, XY_Y=0x123, XY_VALID=1.
  - Frame length 100 cycles.
- Averaging: TOUCH_AVG_EN defined, X samples 100, 101, 102, 105 -> XY_X=102 (408>>2); 8 CS_N frames per poll.
- Pen up: TS_PENIRQ_N high at CHECK -> no CS_N activity, PEN_DOWN=0, VALID stays 0.
- Pen released during the Y frame -> result discarded, PEN_DOWN=0, VALID unchanged.
- Backpressure: hold XY_READY=0 across two polls.
  - The first pair is held and OVERRUN pulses for 1 cycle on the second poll.
  - Assert READY in the same cycle as the second PRESENT: the new pair is loaded and there is no OVERRUN.
